// File: rtl/spi_control_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// single-byte transmit-only SPI master.
package spi_control_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned SCLK_HALF_DEF   = 16;
  localparam int unsigned HOLD_CYCLES_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_control.sv
// Transmit-only SPI master: sends one byte MSB first with CPOL=1/CPHA=1,
// holds CS for a few cycles after the last bit, then pulses SPI_FIN.
module spi_control
  import spi_control_pkg::*;
#(
  parameter int unsigned SCLK_HALF   = SCLK_HALF_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPI_EN,
  input  logic [DATA_W-1:0] SPI_DATA,
  output logic              CS,
  output logic              SDO,
  output logic              SCLK,
  output logic              SPI_FIN
);

  localparam int unsigned DIV_W  = cnt_width(SCLK_HALF);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

  state_t                current_state;
  state_t                state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic                  sclk_phase;
  logic                  phase_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_nxt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [HOLD_W-1:0]     hold_nxt;
  logic [DATA_W-1:0]     shift_reg;
  logic [DATA_W-1:0]     shift_nxt;
  logic                  cs_nxt;
  logic                  sdo_nxt;
  logic                  sclk_nxt;
  logic                  fin_nxt;

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      current_state <= IDLE;
      div_cnt       <= '0;
      sclk_phase    <= 1'b0;
      bit_cnt       <= '0;
      hold_cnt      <= '0;
      shift_reg     <= '0;
    end else begin
      current_state <= state_nxt;
      div_cnt       <= div_nxt;
      sclk_phase    <= phase_nxt;
      bit_cnt       <= bit_nxt;
      hold_cnt      <= hold_nxt;
      shift_reg     <= shift_nxt;
    end
  end

  // Next-state, counter and shift logic.
  always_comb begin
    state_nxt = current_state;
    div_nxt   = div_cnt;
    phase_nxt = sclk_phase;
    bit_nxt   = bit_cnt;
    hold_nxt  = hold_cnt;
    shift_nxt = shift_reg;

    case (current_state)
      IDLE: begin
        if (SPI_EN) begin
          state_nxt = SEND;
          shift_nxt = SPI_DATA;
          div_nxt   = '0;
          phase_nxt = 1'b0;
          bit_nxt   = '0;
        end
      end

      SEND: begin
        if (div_cnt == DIV_W'(SCLK_HALF - 1)) begin
          div_nxt = '0;
          if (!sclk_phase) begin
            phase_nxt = 1'b1;
          end else if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
            // Last bit stays in shift_reg[MSB] so SDO holds it through HOLD.
            state_nxt = HOLD;
            hold_nxt  = '0;
          end else begin
            bit_nxt   = bit_cnt + BIT_CNT_W'(1);
            shift_nxt = {shift_reg[DATA_W-2:0], 1'b0};
            phase_nxt = 1'b0;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end

      HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nxt = DONE;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end

      DONE: begin
        if (!SPI_EN) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // exactly with current_state.
  always_comb begin
    cs_nxt   = 1'b1;
    sclk_nxt = 1'b1;
    sdo_nxt  = 1'b1;
    fin_nxt  = 1'b0;
    case (state_nxt)
      SEND: begin
        cs_nxt   = 1'b0;
        sclk_nxt = phase_nxt;
        sdo_nxt  = shift_nxt[DATA_W-1];
      end
      HOLD: begin
        cs_nxt  = 1'b0;
        sdo_nxt = shift_nxt[DATA_W-1];
      end
      DONE:    fin_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CS      <= 1'b1;
      SCLK    <= 1'b1;
      SDO     <= 1'b1;
      SPI_FIN <= 1'b0;
    end else begin
      CS      <= cs_nxt;
      SCLK    <= sclk_nxt;
      SDO     <= sdo_nxt;
      SPI_FIN <= fin_nxt;
    end
  end

endmodule

// File: tb/tb_spi_control.sv
// Directed bench for spi_control: decodes SDO on SCLK rising edges and checks
// byte value, framing, latency, SPI_FIN behaviour and async reset.
module tb_spi_control;
  import spi_control_pkg::*;

  logic       CLK;
  logic       RST;
  logic       SPI_EN;
  logic [7:0] SPI_DATA;
  logic       CS;
  logic       SDO;
  logic       SCLK;
  logic       SPI_FIN;

  int n_checks = 0;
  int n_errors = 0;

  spi_control dut (
    .CLK      (CLK),
    .RST      (RST),
    .SPI_EN   (SPI_EN),
    .SPI_DATA (SPI_DATA),
    .CS       (CS),
    .SDO      (SDO),
    .SCLK     (SCLK),
    .SPI_FIN  (SPI_FIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: 2-cycle request; mode 1: 1-cycle request plus a stray request and
  // data change mid-transfer; mode 2: request held until 5 cycles after SPI_FIN.
  task automatic run_xfer(input string name, input logic [7:0] data, input int mode,
                          input logic [7:0] exp_byte);
    int         cs_low   = 0;
    int         rises    = 0;
    int         first_cs = -1;
    int         fin_at   = -1;
    int         fin_len  = 0;
    int         viol     = 0;
    bit         done     = 0;
    logic [7:0] got      = 8'h00;
    logic       prev_sclk = 1'b1;
    logic       prev_sdo  = 1'b1;
    logic       prev_cs   = 1'b1;
    SPI_DATA = data;
    SPI_EN   = 1'b1;
    for (int k = 1; k <= 700 && !done; k++) begin
      @(negedge CLK);
      if (!CS) begin
        cs_low++;
        if (first_cs < 0) first_cs = k;
      end
      if (!CS && SCLK && !prev_sclk) begin
        got = {got[6:0], SDO};
        rises++;
      end
      if (!CS && !prev_cs && (SDO != prev_sdo) && !(prev_sclk && !SCLK)) viol++;
      if (SPI_FIN) begin
        if (fin_at < 0) begin
          fin_at = k;
          check({name, " cs_at_fin"}, 32'(CS), 32'd1);
          check({name, " sclk_at_fin"}, 32'(SCLK), 32'd1);
        end
        fin_len++;
      end
      if (fin_at >= 0 && !SPI_FIN) begin
        done = 1;
        check({name, " state_after"}, 32'(dut.current_state), 32'(IDLE));
      end
      prev_sclk = SCLK;
      prev_sdo  = SDO;
      prev_cs   = CS;
      case (mode)
        0: if (k == 2) SPI_EN = 1'b0;
        1: begin
          if (k == 1) SPI_EN = 1'b0;
          if (k == 100) begin
            SPI_DATA = ~data;
            SPI_EN   = 1'b1;
          end
          if (k == 101) SPI_EN = 1'b0;
        end
        default: if (fin_at >= 0 && k == fin_at + 5) SPI_EN = 1'b0;
      endcase
    end
    SPI_EN = 1'b0;
    check({name, " completed"}, 32'(done), 32'd1);
    check({name, " byte"}, 32'(got), 32'(exp_byte));
    check({name, " sclk_rises"}, 32'(rises), 32'd8);
    check({name, " cs_low_cycles"}, 32'(cs_low), 32'd260);
    check({name, " fin_latency"}, 32'(fin_at - first_cs), 32'd260);
    check({name, " fin_width"}, 32'(fin_len), (mode == 2) ? 32'd6 : 32'd1);
    check({name, " sdo_stable"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int cs_seen;
    RST      = 1'b1;
    SPI_EN   = 1'b0;
    SPI_DATA = 8'h00;

    // Reset
    #50;
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_sdo", 32'(SDO), 32'd1);
    check("rst_fin", 32'(SPI_FIN), 32'd0);
    check("rst_state", 32'(dut.current_state), 32'(IDLE));
    #50;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_cs", 32'(CS), 32'd1);
    check("idle_sclk", 32'(SCLK), 32'd1);

    run_xfer("a5", 8'hA5, 0, 8'hA5);
    #100;
    @(negedge CLK);
    run_xfer("3c", 8'h3C, 0, 8'h3C);

    // Back-to-back: request lands in the first IDLE cycle after DONE
    run_xfer("mid", 8'h5A, 1, 8'h5A);
    cs_seen = 0;
    repeat (300) begin
      @(negedge CLK);
      if (!CS) cs_seen++;
    end
    check("no_extra_xfer", 32'(cs_seen), 32'd0);

    run_xfer("held", 8'hC3, 2, 8'hC3);
    repeat (3) @(negedge CLK);

    // Async reset during bit 3
    SPI_DATA = 8'hF0;
    SPI_EN   = 1'b1;
    @(negedge CLK);
    SPI_EN = 1'b0;
    repeat (3 * 32 + 10) @(negedge CLK);
    check("pre_rst_cs_low", 32'(CS), 32'd0);
    #2;
    RST = 1'b1;
    #1;
    check("async_cs", 32'(CS), 32'd1);
    check("async_sclk", 32'(SCLK), 32'd1);
    check("async_sdo", 32'(SDO), 32'd1);
    check("async_fin", 32'(SPI_FIN), 32'd0);
    check("async_state", 32'(dut.current_state), 32'(IDLE));
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_xfer("after_rst", 8'h96, 0, 8'h96);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
